if_fetch_unit: RTL and testbench

- Instruction-fetch producer that drives the IR/PC4 pair consumed by the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Holds one fetched instruction in an output slot plus one skid entry, honours stall from the hazard unit, and redirects on branch/jump resolved in ID.

---
 rtl/if_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer feeding IF/ID: owns the PC, runs the imem req/ack handshake,
// holds one output slot plus one skid entry. Optional MIPS delay slot: define DELAY_SLOT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IR,
    output logic [31:0] PC4,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_SKID  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
    } fetch_word_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_q, drain_d;
    fetch_word_t slot_q, slot_d;
    logic        slot_vld_q, slot_vld_d;
    fetch_word_t skid_q, skid_d;
`ifdef DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    logic        fire;
    logic        consume;
    logic [31:0] pc_inc;
    logic [31:0] pc_seq;
    fetch_word_t fetched;

    // Request is masked by reset so nothing is issued while held in reset.
    assign imem_req  = reset && (state_q != S_SKID);
    assign imem_addr = (state_q == S_DRAIN) ? drain_q : pc_q;
    assign fire      = imem_req && imem_ack;
    assign consume   = slot_vld_q && !stall;
    assign pc_inc    = pc_q + 32'd4;
    assign fetched   = '{ir: imem_rdata, pc4: pc_inc};

`ifdef DELAY_SLOT_EN
    assign pc_seq = pend_q ? pend_pc_q : pc_inc;
`else
    assign pc_seq = pc_inc;
`endif

    assign if_valid = slot_vld_q;
    assign IR       = slot_vld_q ? slot_q.ir  : 32'h0;
    assign PC4      = slot_vld_q ? slot_q.pc4 : 32'h0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drain_d    = drain_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q;
        skid_d     = skid_q;
`ifdef DELAY_SLOT_EN
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
`endif

        case (state_q)
            S_FETCH: begin
                if (fire) begin
                    pc_d = pc_seq;
`ifdef DELAY_SLOT_EN
                    pend_d = 1'b0;
`endif
                    if (!slot_vld_q || consume) begin
                        slot_d     = fetched;
                        slot_vld_d = 1'b1;
                    end else begin
                        skid_d  = fetched;
                        state_d = S_SKID;
                    end
                end else if (consume) begin
                    slot_vld_d = 1'b0;
                end
            end
            S_SKID: begin
                if (!stall) begin
                    slot_d     = skid_q;
                    slot_vld_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The returning word belongs to the abandoned path; pc is already retargeted.
                if (consume) slot_vld_d = 1'b0;
                if (fire)    state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

`ifdef DELAY_SLOT_EN
        if (redirect) begin
            if (pend_q) begin
                // Delay-slot fetch still outstanding: retarget only.
                if (fire) pc_d      = redirect_pc;
                else      pend_pc_d = redirect_pc;
            end else if (state_q == S_FETCH && slot_vld_q && !consume) begin
                // Delay slot already sits in the output slot; anything in flight is past it.
                pc_d = redirect_pc;
                if (fire) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = imem_addr;
                end
            end else if (state_q == S_FETCH) begin
                if (fire) begin
                    pc_d = redirect_pc;
                end else begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end else begin
                pc_d = redirect_pc;
            end
        end
`else
        if (redirect) begin
            pc_d       = redirect_pc;
            slot_vld_d = 1'b0;
            skid_d     = '0;
            if (imem_req && !imem_ack) begin
                state_d = S_DRAIN;
                drain_d = imem_addr;
            end else begin
                state_d = S_FETCH;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            drain_q    <= RESET_PC;
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            skid_q     <= '0;
`ifdef DELAY_SLOT_EN
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drain_q    <= drain_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            skid_q     <= skid_d;
`ifdef DELAY_SLOT_EN
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetched words go into a scoreboard queue when acked,
// and are popped and compared when the DUT's output slot is consumed.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IR;
    logic [31:0] PC4;
    logic        if_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .IR(IR), .PC4(PC4), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] pc4);
        exp_q.push_back({wd(a), pc4});
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
    endtask

    // Slot consumed at the coming edge: the word shown must be the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
            chk("sb_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ir", IR, e[63:32]);
                chk("sb_pc4", PC4, e[31:0]);
            end
        end
    end

    initial begin
        logic [31:0] a;
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_vld", if_valid, 1'b0);
        chk("rst_ir", IR, 32'h0);
        chk("rst_pc4", PC4, 32'h0);
        reset = 1'b1;
        #1;
        chkb("rel_req", imem_req, 1'b1);

        // back-to-back fetch, ack every cycle
        for (int i = 0; i < 3; i++) begin
            a = RST_PC + 32'(4 * i);
            chk("s1_addr", imem_addr, a);
            imem_ack = 1'b1; imem_rdata = wd(a); push(a, a + 32'd4);
            tick();
            chkb("s1_vld", if_valid, 1'b1);
        end
        imem_ack = 1'b0;
        tick();
        chkb("s1_drop", if_valid, 1'b0);
        chk("s1_next", imem_addr, 32'h0000_300C);

        // three-cycle ack latency
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chkb("s2_req", imem_req, 1'b1);
            chk("s2_addr", imem_addr, RST_PC);
            chkb("s2_vld", if_valid, 1'b0);
            chk("s2_ir", IR, 32'h0);
            tick();
        end
        imem_ack = 1'b1; imem_rdata = wd(RST_PC); push(RST_PC, 32'h0000_3004);
        tick();
        chkb("s2_vld1", if_valid, 1'b1);

        // stall for 4 edges: second word skids, acks ignored while req low
        stall = 1'b1; imem_rdata = wd(32'h0000_3004); push(32'h0000_3004, 32'h0000_3008);
        tick();
        for (int i = 0; i < 3; i++) begin
            chkb("s3_req", imem_req, 1'b0);
            chk("s3_ir", IR, wd(RST_PC));
            imem_rdata = 32'hDEAD_BEEF;
            tick();
        end
        chkb("s3_req4", imem_req, 1'b0);
        stall = 1'b0; imem_ack = 1'b0;
        tick();
        chk("s3_skid_ir", IR, wd(32'h0000_3004));
        chk("s3_skid_pc4", PC4, 32'h0000_3008);
        chk("s3_resume", imem_addr, 32'h0000_3008);
        chkb("s3_req_up", imem_req, 1'b1);

        // redirect with a request outstanding
        imem_ack = 1'b1; imem_rdata = wd(32'h0000_3008); push(32'h0000_3008, 32'h0000_300C);
        tick();
        imem_ack = 1'b0;
        tick();
        chk("s4_out", imem_addr, 32'h0000_300C);
        redirect = 1'b1; redirect_pc = 32'h0000_3100; imem_rdata = wd(32'h0000_300C);
        tick();
        chkb("s4_vld", if_valid, 1'b0);
        chkb("s4_req", imem_req, 1'b1);
        chk("s4_hold", imem_addr, 32'h0000_300C);
        redirect = 1'b0;
        tick();
        chk("s4_hold2", imem_addr, 32'h0000_300C);
        imem_ack = 1'b1;
        if (DS) push(32'h0000_300C, 32'h0000_3010);
        tick();
        chk("s4_tgt", imem_addr, 32'h0000_3100);
        chkb("s4_vld2", if_valid, DS);

        // redirect and stall in the same cycle
        imem_rdata = wd(32'h0000_3100); push(32'h0000_3100, 32'h0000_3104);
        tick();
        chkb("s5_vld", if_valid, 1'b1);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3100; imem_rdata = wd(32'h0000_3104);
        tick();
        chkb("s5_flush", if_valid, DS);
        chk("s5_ir", IR, DS ? wd(32'h0000_3100) : 32'h0);
        chk("s5_addr", imem_addr, 32'h0000_3100);
        chkb("s5_req", imem_req, 1'b1);
        if (!DS) void'(exp_q.pop_front());
        stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        tick();
        chkb("s5_vld2", if_valid, 1'b0);
        chk("s5_addr2", imem_addr, 32'h0000_3100);

        // pc wrap and unaligned redirect target
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = wd(32'h0000_3100);
        if (DS) push(32'h0000_3100, 32'h0000_3104);
        tick();
        chk("w_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_rdata = wd(32'hFFFF_FFFC); push(32'hFFFF_FFFC, 32'h0);
        tick();
        chk("w_wrap", imem_addr, 32'h0);
        chk("w_pc4", PC4, 32'h0);
        chkb("w_vld", if_valid, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h0000_3102; imem_rdata = wd(32'h0);
        if (DS) push(32'h0, 32'h4);
        tick();
        chk("w_unal", imem_addr, 32'h0000_3102);
        chkb("w_vld2", if_valid, DS);
        redirect = 1'b0; imem_ack = 1'b0;
        tick();

        // reset asserted while in the skid state
        imem_ack = 1'b1; imem_rdata = wd(32'h0000_3102); push(32'h0000_3102, 32'h0000_3106);
        tick();
        stall = 1'b1; imem_rdata = wd(32'h0000_3106);
        tick();
        chkb("s6_skid_req", imem_req, 1'b0);
        chkb("s6_skid_vld", if_valid, 1'b1);
        imem_ack = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chkb("s6_req", imem_req, 1'b0);
        chkb("s6_vld", if_valid, 1'b0);
        chk("s6_ir", IR, 32'h0);
        chk("s6_pc4", PC4, 32'h0);
        exp_q.delete();
        stall = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chkb("s6_rel_req", imem_req, 1'b1);
        chk("s6_rel_addr", imem_addr, RST_PC);
        imem_ack = 1'b1; imem_rdata = wd(RST_PC); push(RST_PC, 32'h0000_3004);
        tick();
        imem_ack = 1'b0;
        tick(); tick();

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
